// File: rtl/uart_pkg.sv
// Shared UART bit-timing derivation so the receiver and transmitter agree on
// the number of clocks per bit and where mid-bit falls.
package uart_pkg;

    localparam int DEFAULT_BAUD   = 115200;
    localparam int DEFAULT_CLK_HZ = 25000000;

    function automatic int clksPerBit(input int clkHz, input int baud);
        return clkHz / baud;
    endfunction

    function automatic int halfBit(input int clkHz, input int baud);
        return clksPerBit(clkHz, baud) / 2;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is a
// parameter so idle-high lines come out of reset in their idle state.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver: synchronizes the line, samples each bit at its
// middle and presents a good byte with a one-cycle strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD   = DEFAULT_BAUD,
    parameter int CLK_HZ = DEFAULT_CLK_HZ
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int CLKS_PER_BIT = clksPerBit(CLK_HZ, BAUD);
    localparam int HALF_BIT     = halfBit(CLK_HZ, BAUD);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bitIdx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_frameErr;

    state_t           w_nextState;
    logic [CNT_W-1:0] w_nextCnt;
    logic [2:0]       w_nextBitIdx;
    logic [7:0]       w_nextShift;
    logic [7:0]       w_nextData;
    logic             w_nextValid;
    logic             w_nextFrameErr;
    logic             w_rxS;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_rx),
        .o_q    (w_rxS)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bitIdx   <= '0;
            r_shift    <= '0;
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_frameErr <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_cnt      <= w_nextCnt;
            r_bitIdx   <= w_nextBitIdx;
            r_shift    <= w_nextShift;
            r_data     <= w_nextData;
            r_valid    <= w_nextValid;
            r_frameErr <= w_nextFrameErr;
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_nextCnt      = r_cnt;
        w_nextBitIdx   = r_bitIdx;
        w_nextShift    = r_shift;
        w_nextData     = r_data;
        w_nextValid    = 1'b0;
        w_nextFrameErr = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_rxS) begin
                    w_nextState = S_START;
                    w_nextCnt   = '0;
                end
            end

            // A start bit that is gone again by mid-bit was only a glitch.
            S_START: begin
                if (r_cnt == CNT_HALF_LAST) begin
                    w_nextCnt = '0;
                    if (!w_rxS) begin
                        w_nextState  = S_DATA;
                        w_nextBitIdx = '0;
                    end else begin
                        w_nextState = S_IDLE;
                    end
                end else begin
                    w_nextCnt = r_cnt + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (r_cnt == CNT_BIT_LAST) begin
                    w_nextCnt    = '0;
                    w_nextShift  = {w_rxS, r_shift[7:1]};
                    w_nextBitIdx = r_bitIdx + 3'd1;
                    if (r_bitIdx == 3'd7) begin
                        w_nextState = S_STOP;
                    end
                end else begin
                    w_nextCnt = r_cnt + CNT_W'(1);
                end
            end

            // Leaving at mid-stop gives half a bit of slack to catch a back-to-back start.
            S_STOP: begin
                if (r_cnt == CNT_BIT_LAST) begin
                    w_nextCnt = '0;
                    if (w_rxS) begin
                        w_nextData  = r_shift;
                        w_nextValid = 1'b1;
                        w_nextState = S_IDLE;
                    end else begin
                        w_nextFrameErr = 1'b1;
                        w_nextState    = S_BREAK;
                    end
                end else begin
                    w_nextCnt = r_cnt + CNT_W'(1);
                end
            end

            S_BREAK: begin
                if (w_rxS) begin
                    w_nextState = S_IDLE;
                end
            end

            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frameErr;
    assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames plus hand-written
// glitch, bad-stop, back-to-back and reset-mid-frame sequences.
module tb_uart_rx;

    localparam int CPB = 217;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frameErr;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int   cycle        = 0;
    int   validCnt     = 0;
    int   errCnt       = 0;
    int   overlapCnt   = 0;
    int   consecCnt    = 0;
    int   lastValidCyc = 0;
    int   prevValidCyc = 0;
    logic [7:0] lastData = 8'h00;
    logic [7:0] prevData = 8'h00;
    logic prevStrobe = 1'b0;

    typedef struct {
        logic [7:0] txByte;
        int         bitClks;
        int         expValid;
        int         expErr;
        logic [7:0] expData;
    } vec_t;

    vec_t vecs [5];

    uart_rx #(
        .BAUD  (115200),
        .CLK_HZ(25000000)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx       (rx),
        .o_data     (data),
        .o_valid    (valid),
        .o_frame_err(frameErr),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        cycle = cycle + 1;
        if (valid && frameErr) overlapCnt = overlapCnt + 1;
        if ((valid || frameErr) && prevStrobe) consecCnt = consecCnt + 1;
        prevStrobe = valid || frameErr;
        if (valid) begin
            validCnt     = validCnt + 1;
            prevData     = lastData;
            lastData     = data;
            prevValidCyc = lastValidCyc;
            lastValidCyc = cycle;
        end
        if (frameErr) errCnt = errCnt + 1;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        total = total + 1;
        if (actual !== expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic sendFrame(input logic [7:0] b, input int bitClks, input logic stopBit);
        rx = 1'b0;
        waitCycles(bitClks);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            waitCycles(bitClks);
        end
        rx = stopBit;
        waitCycles(bitClks);
    endtask

    task automatic applyStimulus(input vec_t v);
        sendFrame(v.txByte, v.bitClks, 1'b1);
        rx = 1'b1;
        waitCycles(400);
    endtask

    initial begin
        int v0;
        int e0;
        vecs[0] = '{txByte: 8'hA5, bitClks: CPB, expValid: 1, expErr: 0, expData: 8'hA5};
        vecs[1] = '{txByte: 8'h00, bitClks: CPB, expValid: 1, expErr: 0, expData: 8'h00};
        vecs[2] = '{txByte: 8'hFF, bitClks: CPB, expValid: 1, expErr: 0, expData: 8'hFF};
        vecs[3] = '{txByte: 8'h96, bitClks: 227, expValid: 1, expErr: 0, expData: 8'h96};
        vecs[4] = '{txByte: 8'h96, bitClks: 207, expValid: 1, expErr: 0, expData: 8'h96};

        rx    = 1'b1;
        rst_n = 1'b0;
        waitCycles(5);
        checkOutput("reset data", int'(data), 8'h00);
        checkOutput("reset valid", int'(valid), 0);
        checkOutput("reset frame_err", int'(frameErr), 0);
        checkOutput("reset busy", int'(busy), 0);
        rst_n = 1'b1;
        waitCycles(20);

        for (int i = 0; i < 5; i++) begin
            v0 = validCnt;
            e0 = errCnt;
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d valid count", i), validCnt - v0, vecs[i].expValid);
            checkOutput($sformatf("vec%0d frame_err count", i), errCnt - e0, vecs[i].expErr);
            checkOutput($sformatf("vec%0d data", i), int'(data), int'(vecs[i].expData));
            checkOutput($sformatf("vec%0d busy idle", i), int'(busy), 0);
        end

        // Glitch: short low pulse must be rejected at mid start bit.
        v0 = validCnt;
        e0 = errCnt;
        rx = 1'b0;
        waitCycles(50);
        rx = 1'b1;
        waitCycles(20);
        checkOutput("glitch busy during", int'(busy), 1);
        waitCycles(110);
        checkOutput("glitch busy after", int'(busy), 0);
        checkOutput("glitch valid count", validCnt - v0, 0);
        checkOutput("glitch frame_err count", errCnt - e0, 0);

        // Bad stop bit followed by a long break.
        v0 = validCnt;
        e0 = errCnt;
        sendFrame(8'h3C, CPB, 1'b0);
        waitCycles(5000);
        checkOutput("badstop frame_err count", errCnt - e0, 1);
        checkOutput("badstop valid count", validCnt - v0, 0);
        checkOutput("badstop data kept", int'(data), 8'h96);
        checkOutput("badstop busy in break", int'(busy), 1);
        rx = 1'b1;
        waitCycles(10);
        checkOutput("badstop busy released", int'(busy), 0);
        waitCycles(400);
        checkOutput("badstop no extra err", errCnt - e0, 1);
        checkOutput("badstop no extra valid", validCnt - v0, 0);

        // Back-to-back frames with no idle gap between them.
        v0 = validCnt;
        sendFrame(8'h55, CPB, 1'b1);
        sendFrame(8'hAA, CPB, 1'b1);
        rx = 1'b1;
        waitCycles(400);
        checkOutput("b2b valid count", validCnt - v0, 2);
        checkOutput("b2b first data", int'(prevData), 8'h55);
        checkOutput("b2b second data", int'(lastData), 8'hAA);
        checkOutput("b2b spacing", lastValidCyc - prevValidCyc, 10 * CPB);

        // Reset during bit 4 of 0xC3.
        v0 = validCnt;
        rx = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = ((8'hC3 >> i) & 8'h01) != 0;
            waitCycles(CPB);
        end
        rx = 1'b0;
        waitCycles(100);
        rst_n = 1'b0;
        #1;
        checkOutput("rst mid data", int'(data), 8'h00);
        checkOutput("rst mid busy", int'(busy), 0);
        checkOutput("rst mid valid", int'(valid), 0);
        rx = 1'b1;
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(3000);
        checkOutput("rst mid no valid", validCnt - v0, 0);
        checkOutput("rst mid data held", int'(data), 8'h00);
        sendFrame(8'h81, CPB, 1'b1);
        rx = 1'b1;
        waitCycles(400);
        checkOutput("post-reset valid count", validCnt - v0, 1);
        checkOutput("post-reset data", int'(data), 8'h81);

        checkOutput("valid/frame_err overlap", overlapCnt, 0);
        checkOutput("consecutive strobes", consecCnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
